// File: rtl/vga_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vga_capture : VGA receive path - sync recovery, timing lock, pixel capture |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module vga_capture #(
   parameter int   H_ACTIVE    = 640,
   parameter int   V_ACTIVE    = 480,
   parameter int   H_BACK      = 144,
   parameter int   V_BACK      = 35,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   LOCK_FRAMES = 2
) (
   input  logic        clk_25m,
   input  logic        rst_n,
   input  logic        vga_hs,
   input  logic        vga_vs,
   input  logic [23:0] vga_rgb,
   output logic        cap_valid,
   output logic [11:0] cap_xpos,
   output logic [11:0] cap_ypos,
   output logic [23:0] cap_data,
   output logic        frame_start,
   output logic        locked,
   output logic [11:0] h_total,
   output logic [11:0] v_total,
   output logic        sync_err
);

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   localparam logic [11:0] H_FIRST    = 12'(H_BACK);
   localparam logic [11:0] H_END      = 12'(H_BACK + H_ACTIVE);
   localparam logic [11:0] V_FIRST    = 12'(V_BACK);
   localparam logic [11:0] V_END      = 12'(V_BACK + V_ACTIVE);
   localparam logic [11:0] CNT_MAX    = 12'hFFF;
   localparam logic [7:0]  MATCH_LOCK = 8'(LOCK_FRAMES);

   state_t      state;
   logic        s_hs, s_vs, p_hs, p_vs;
   logic [23:0] s_rgb, d_rgb;
   logic [11:0] h_cnt, v_cnt, ref_h, ref_v;
   logic        seen_h, line_ok;
   logic [7:0]  match_cnt;

   logic        hs_edge, vs_edge, active, err, frame_ok, meas_ok;
   logic [11:0] h_len, h_meas, v_meas;

   // h_cnt is aligned with the twice-registered sync, so the pixel paired
   // with it is d_rgb (second rgb stage), not s_rgb.
   always_comb begin
      hs_edge  = (s_hs == SYNC_POL) && (p_hs != SYNC_POL);
      vs_edge  = (s_vs == SYNC_POL) && (p_vs != SYNC_POL);
      h_len    = (h_cnt == CNT_MAX) ? CNT_MAX : h_cnt + 12'd1;
      h_meas   = (hs_edge && seen_h) ? h_len : h_total;
      v_meas   = v_cnt + {11'd0, hs_edge};
      active   = (h_cnt >= H_FIRST) && (h_cnt < H_END) &&
                 (v_cnt >= V_FIRST) && (v_cnt < V_END);
      frame_ok = line_ok && (!hs_edge || (h_len == ref_h));
      meas_ok  = (h_meas == ref_h) && (v_meas == ref_v) && frame_ok;
      err      = (hs_edge && (h_len != ref_h)) ||
                 (vs_edge && (v_meas != ref_v)) ||
                 (h_cnt == CNT_MAX);
   end

   always_ff @(posedge clk_25m) begin
      if (!rst_n) begin
         s_hs        <= 1'b0;
         s_vs        <= 1'b0;
         p_hs        <= 1'b0;
         p_vs        <= 1'b0;
         s_rgb       <= '0;
         d_rgb       <= '0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         ref_h       <= '0;
         ref_v       <= '0;
         seen_h      <= 1'b0;
         line_ok     <= 1'b0;
         match_cnt   <= '0;
         state       <= SEARCH;
         cap_valid   <= 1'b0;
         cap_xpos    <= '0;
         cap_ypos    <= '0;
         cap_data    <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         h_total     <= '0;
         v_total     <= '0;
         sync_err    <= 1'b0;
      end else begin
         s_hs  <= vga_hs;
         s_vs  <= vga_vs;
         p_hs  <= s_hs;
         p_vs  <= s_vs;
         s_rgb <= vga_rgb;
         d_rgb <= s_rgb;

         if (hs_edge)
            h_cnt <= '0;
         else if (h_cnt != CNT_MAX)
            h_cnt <= h_cnt + 12'd1;

         // The first hs edge after reset only opens a line; nothing to report yet.
         if (hs_edge) begin
            seen_h <= 1'b1;
            if (seen_h)
               h_total <= h_len;
         end

         if (vs_edge)
            v_cnt <= '0;
         else if (hs_edge && (v_cnt != CNT_MAX))
            v_cnt <= v_cnt + 12'd1;

         if (vs_edge)
            v_total <= v_meas;

         if (vs_edge)
            line_ok <= 1'b1;
         else if (hs_edge && (h_len != ref_h))
            line_ok <= 1'b0;

         frame_start <= 1'b0;
         sync_err    <= 1'b0;

         case (state)
            SEARCH: begin
               if (vs_edge) begin
                  state     <= MEASURE;
                  match_cnt <= '0;
                  ref_h     <= h_meas;
                  ref_v     <= '0;
               end
            end
            MEASURE: begin
               if (vs_edge) begin
                  if (meas_ok) begin
                     match_cnt <= match_cnt + 8'd1;
                     if ((match_cnt + 8'd1) == MATCH_LOCK) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end
                  end else begin
                     match_cnt <= '0;
                     ref_h     <= h_meas;
                     ref_v     <= v_meas;
                  end
               end
            end
            LOCKED: begin
               if (err) begin
                  sync_err <= 1'b1;
                  locked   <= 1'b0;
                  state    <= SEARCH;
               end else if (vs_edge) begin
                  frame_start <= 1'b1;
               end
            end
            default: begin
               state  <= SEARCH;
               locked <= 1'b0;
            end
         endcase

         // Coordinates and data only move on emitted pixels; they hold otherwise.
         cap_valid <= (state == LOCKED) && !err && active;
         if ((state == LOCKED) && !err && active) begin
            cap_xpos <= h_cnt - H_FIRST;
            cap_ypos <= v_cnt - V_FIRST;
            cap_data <= d_rgb;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_vga_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vga_capture : directed scoreboard bench for vga_capture (reduced timing) |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_vga_capture;

   localparam int H_TOT  = 16;
   localparam int HS_W   = 2;
   localparam int H_BACK = 4;
   localparam int H_ACT  = 8;
   localparam int V_TOT  = 10;
   localparam int VS_W   = 1;
   localparam int V_BACK = 2;
   localparam int V_ACT  = 4;
   localparam int PIX_PER_FRAME = H_ACT * V_ACT;

   typedef struct {
      logic [11:0] x;
      logic [11:0] y;
      logic [23:0] d;
      int          c;
   } pix_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vga_hs = 1'b1;
   logic        vga_vs = 1'b1;
   logic [23:0] vga_rgb = '0;
   logic        cap_valid, frame_start, locked, sync_err;
   logic [11:0] cap_xpos, cap_ypos, h_total, v_total;
   logic [23:0] cap_data;

   vga_capture #(
      .H_ACTIVE   (H_ACT),
      .V_ACTIVE   (V_ACT),
      .H_BACK     (H_BACK),
      .V_BACK     (V_BACK),
      .SYNC_POL   (1'b0),
      .LOCK_FRAMES(2)
   ) dut (
      .clk_25m    (clk),
      .rst_n      (rst_n),
      .vga_hs     (vga_hs),
      .vga_vs     (vga_vs),
      .vga_rgb    (vga_rgb),
      .cap_valid  (cap_valid),
      .cap_xpos   (cap_xpos),
      .cap_ypos   (cap_ypos),
      .cap_data   (cap_data),
      .frame_start(frame_start),
      .locked     (locked),
      .h_total    (h_total),
      .v_total    (v_total),
      .sync_err   (sync_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   checks = 0;
   int   failures = 0;
   pix_t sb[$];

   int   hc = 0, vc = 0, line_len = H_TOT;
   bit   exp_cap = 1'b0;
   bit   src_idle = 1'b1;
   logic rst_val = 1'b0;
   int   drv_cyc = 0, frame_cyc = 0;

   int          valid_cnt = 0, fs_cnt = 0, err_cnt = 0;
   int          last_fs_cyc = -1, last_err_cyc = -1;
   logic [11:0] last_x = '0, last_y = '0;
   pix_t        mon_e;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One source clock: drive sync/rgb at negedge, log expected pixels with their due cycle.
   task automatic step();
      pix_t px;
      @(negedge clk);
      rst_n   = rst_val;
      drv_cyc = cyc;
      if (src_idle) begin
         vga_hs  = 1'b1;
         vga_vs  = 1'b1;
         vga_rgb = '0;
      end else begin
         vga_hs = (hc < HS_W) ? 1'b0 : 1'b1;
         vga_vs = (vc < VS_W) ? 1'b0 : 1'b1;
         if (hc >= H_BACK && hc < H_BACK + H_ACT && vc >= V_BACK && vc < V_BACK + V_ACT) begin
            px.x    = 12'(hc - H_BACK);
            px.y    = 12'(vc - V_BACK);
            px.d    = {px.x, px.y};
            px.c    = cyc + 3;
            vga_rgb = px.d;
            if (exp_cap) sb.push_back(px);
         end else begin
            vga_rgb = 24'($urandom);
         end
         if (hc == 0 && vc == 0) frame_cyc = cyc;
         hc++;
         if (hc >= line_len) begin
            hc       = 0;
            line_len = H_TOT;
            vc       = (vc + 1) % V_TOT;
         end
      end
   endtask

   task automatic run_lines(input int n);
      repeat (n) begin
         step();
         while (hc != 0) step();
      end
   endtask

   task automatic run_frames(input int n, input bit cap);
      exp_cap = cap;
      run_lines(n * V_TOT);
   endtask

   always @(negedge clk) begin
      if (cap_valid === 1'b1) begin
         valid_cnt++;
         last_x = cap_xpos;
         last_y = cap_ypos;
         chk("valid_expected", sb.size() > 0, 1);
         if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("xpos", cap_xpos, mon_e.x);
            chk("ypos", cap_ypos, mon_e.y);
            chk("data", cap_data, mon_e.d);
            chk("latency", cyc, mon_e.c);
         end
      end
      if (frame_start === 1'b1) begin
         fs_cnt++;
         last_fs_cyc = cyc;
      end
      if (sync_err === 1'b1) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v0, f0, e0, n;

      // Reset with idle source
      rst_val = 1'b0;
      repeat (3) step();
      chk("rst_flags", {cap_valid, locked, frame_start, sync_err}, 4'b0000);
      chk("rst_h_total", h_total, 0);
      chk("rst_v_total", v_total, 0);
      chk("rst_pixel", {cap_xpos, cap_ypos, cap_data}, 0);
      rst_val  = 1'b1;
      step();
      src_idle = 1'b0;

      // Frames 0..2: acquisition, nothing emitted
      run_frames(3, 1'b0);
      chk("unlocked_before_4th_vs", locked, 0);
      chk("h_total", h_total, H_TOT);
      chk("v_total_coincident_edges", v_total, V_TOT);

      // Frame 3: locks on its vs edge and is captured
      v0 = valid_cnt;
      run_frames(1, 1'b1);
      chk("locked", locked, 1);
      chk("valid_count_f3", valid_cnt - v0, PIX_PER_FRAME);
      chk("no_fs_on_lock_edge", fs_cnt, 0);
      chk("last_pixel", {last_x, last_y}, {12'(H_ACT - 1), 12'(V_ACT - 1)});
      chk("sb_drained_f3", sb.size(), 0);

      // Frame 4: steady state, frame_start pulse
      v0 = valid_cnt;
      run_frames(1, 1'b1);
      chk("fs_count", fs_cnt, 1);
      chk("fs_cycle", last_fs_cyc, frame_cyc + 2);
      chk("valid_count_f4", valid_cnt - v0, PIX_PER_FRAME);

      // Frame 5: line 3 is one clock short
      e0 = err_cnt;
      exp_cap = 1'b1;
      run_lines(3);
      line_len = H_TOT - 1;
      run_lines(1);
      exp_cap = 1'b0;
      step();
      n = drv_cyc;
      run_lines(1);
      chk("short_line_err_count", err_cnt - e0, 1);
      chk("short_line_err_cycle", last_err_cyc, n + 2);
      chk("short_line_unlocked", locked, 0);
      run_lines(V_TOT - 5);
      chk("sb_drained_f5", sb.size(), 0);

      // Frames 6..8 clean, relock on frame 9
      run_frames(3, 1'b0);
      chk("unlocked_f8", locked, 0);
      v0 = valid_cnt;
      run_frames(1, 1'b1);
      chk("relocked_f9", locked, 1);
      chk("valid_count_f9", valid_cnt - v0, PIX_PER_FRAME);

      // Frame 10: hs stops after line 2
      e0 = err_cnt;
      exp_cap = 1'b1;
      run_lines(2);
      step();
      n = drv_cyc;
      run_lines(1);
      exp_cap  = 1'b0;
      src_idle = 1'b1;
      repeat (5000) step();
      chk("sat_err_count", err_cnt - e0, 1);
      chk("sat_err_cycle", last_err_cyc, n + 4098);
      chk("sat_h_total_kept", h_total, H_TOT);
      chk("sat_unlocked", locked, 0);
      chk("sb_drained_f10", sb.size(), 0);

      // Frames 11..13 reacquire, frame 14 locked then reset mid-line
      hc = 0;
      vc = 0;
      src_idle = 1'b0;
      run_frames(3, 1'b0);
      exp_cap = 1'b1;
      run_lines(3);
      repeat (6) step();
      exp_cap = 1'b0;
      repeat (2) step();
      rst_val = 1'b0;
      step();
      @(posedge clk);
      #1;
      chk("midline_rst_flags", {cap_valid, locked, frame_start, sync_err}, 4'b0000);
      chk("midline_rst_totals", {h_total, v_total}, 0);
      chk("midline_rst_pixel", {cap_xpos, cap_ypos, cap_data}, 0);
      rst_val = 1'b1;
      run_lines(V_TOT - 3);
      chk("sb_drained_rst", sb.size(), 0);

      // Full relock sequence after reset
      run_frames(3, 1'b0);
      chk("unlocked_f17", locked, 0);
      v0 = valid_cnt;
      f0 = fs_cnt;
      run_frames(1, 1'b1);
      chk("relocked_f18", locked, 1);
      chk("valid_count_f18", valid_cnt - v0, PIX_PER_FRAME);
      chk("no_fs_on_relock_edge", fs_cnt - f0, 0);
      chk("sb_drained_end", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
